// File: rtl/mux_pkg.sv
// Shared definitions for the channel scanner: FSM state encoding and mode values.
package mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        NONE   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_next_ch.sv
// Finds the next enabled channel strictly above cur, wrapping modulo NUM_CH;
// cur itself is the last candidate, so a lone enabled channel maps to itself.
module mux_next_ch #(
    parameter int NUM_CH = 4,
    parameter int SW     = 2
) (
    input  logic [SW-1:0]     cur,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SW-1:0]     nxt,
    output logic              any
);

    int w_best;
    int w_dist;

    // Pick the enabled channel at the smallest forward distance from cur.
    always_comb begin
        nxt    = cur;
        any    = |ch_en;
        w_best = NUM_CH;
        w_dist = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_dist = j - int'(cur) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_CH;
            end
            if (ch_en[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                nxt    = SW'(j);
            end
        end
    end

endmodule

// File: rtl/mux_scanner.sv
// Registered channel selector: manual selection by index, or automatic scanning
// across enabled channels holding each one for dwell+1 cycles.
module mux_scanner
    import mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4,
    localparam int SW     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SW-1:0]           sel,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]        d,
    output logic                    d_valid,
    output logic [SW-1:0]           ch
);

    localparam int IW = $clog2(NUM_CH * WIDTH);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_d;
    logic [SW-1:0]      r_ch;
    logic               r_valid;
    logic [DWELL_W-1:0] r_cnt;

    logic [SW-1:0]      w_nextCh;
    logic               w_nextValid;
    logic [DWELL_W-1:0] w_nextCnt;
    logic               w_load;
    logic [SW-1:0]      w_src;
    logic [SW-1:0]      w_cur;
    logic [SW-1:0]      w_nxt;
    logic               w_any;
    logic               w_selOk;
    logic [IW-1:0]      w_base;
    logic [WIDTH-1:0]   w_pick;

    // Outside SCAN the search starts just below channel 0, yielding the lowest enabled one.
    assign w_cur = (r_state == SCAN) ? r_ch : SW'(NUM_CH - 1);

    mux_next_ch #(
        .NUM_CH (NUM_CH),
        .SW     (SW)
    ) u_next (
        .cur   (w_cur),
        .ch_en (ch_en),
        .nxt   (w_nxt),
        .any   (w_any)
    );

    assign w_selOk = (32'(sel) < 32'(NUM_CH)) && ch_en[sel];
    assign w_base  = IW'(w_src) * IW'(WIDTH);
    assign w_pick  = i_data[w_base +: WIDTH];

    always_comb begin
        w_nextState = r_state;
        w_nextCh    = r_ch;
        w_nextValid = 1'b0;
        w_nextCnt   = r_cnt;
        w_load      = 1'b0;
        w_src       = r_ch;
        if (mode == MODE_MANUAL) begin
            w_nextState = MANUAL;
            if (w_selOk) begin
                w_src       = sel;
                w_load      = 1'b1;
                w_nextCh    = sel;
                w_nextValid = 1'b1;
            end
        end else if (!w_any) begin
            w_nextState = NONE;
        end else if ((r_state != SCAN) || (r_cnt == '0) || !ch_en[r_ch]) begin
            // Scan entry, dwell expiry and a channel disabled under us all move on and reload.
            w_nextState = SCAN;
            w_src       = w_nxt;
            w_load      = 1'b1;
            w_nextCh    = w_nxt;
            w_nextValid = 1'b1;
            w_nextCnt   = dwell;
        end else begin
            w_load      = 1'b1;
            w_nextValid = 1'b1;
            w_nextCnt   = r_cnt - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MANUAL;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ch    <= w_nextCh;
            r_valid <= w_nextValid;
            r_cnt   <= w_nextCnt;
            if (w_load) begin
                r_d <= w_pick;
            end
        end
    end

    assign d       = r_d;
    assign ch      = r_ch;
    assign d_valid = r_valid;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_mux_scanner;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 8;
    localparam int DWELL_W = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [3:0]  chEn = '0;
    logic [3:0]  dwell = '0;
    logic [31:0] iData = '0;
    logic [7:0]  dOut;
    logic        dValid;
    logic [1:0]  chOut;

    int total = 0;
    int bad = 0;

    mux_scanner #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rstN),
        .mode    (mode),
        .sel     (sel),
        .ch_en   (chEn),
        .dwell   (dwell),
        .i_data  (iData),
        .d       (dOut),
        .d_valid (dValid),
        .ch      (chOut)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the outputs must be after each edge.
    logic [7:0] mD = '0;
    int         mCh = 0;
    bit         mValid = 1'b0;
    bit         mScanning = 1'b0;
    int         mLeft = 0;

    function automatic logic [7:0] chData(input logic [31:0] data, input int c);
        return WIDTH'(data >> (c * WIDTH));
    endfunction

    function automatic bit isOn(input logic [3:0] en, input int c);
        return en[2'(c)];
    endfunction

    function automatic int lowestOn(input logic [3:0] en);
        for (int c = 0; c < NUM_CH; c++) begin
            if (isOn(en, c)) return c;
        end
        return 0;
    endfunction

    function automatic int nextOn(input int cur, input logic [3:0] en);
        for (int off = 1; off <= NUM_CH; off++) begin
            if (isOn(en, (cur + off) % NUM_CH)) return (cur + off) % NUM_CH;
        end
        return cur;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mD = '0; mCh = 0; mValid = 1'b0; mScanning = 1'b0; mLeft = 0;
        end else if (mode == 1'b0) begin
            mScanning = 1'b0;
            if ((int'(sel) < NUM_CH) && isOn(chEn, int'(sel))) begin
                mD = chData(iData, int'(sel)); mCh = int'(sel); mValid = 1'b1;
            end else begin
                mValid = 1'b0;
            end
        end else if (chEn == 4'b0000) begin
            mScanning = 1'b0;
            mValid = 1'b0;
        end else begin
            if (!mScanning) begin
                mCh = lowestOn(chEn); mLeft = int'(dwell); mScanning = 1'b1;
            end else if ((mLeft == 0) || !isOn(chEn, mCh)) begin
                mCh = nextOn(mCh, chEn); mLeft = int'(dwell);
            end else begin
                mLeft = mLeft - 1;
            end
            mD = chData(iData, mCh);
            mValid = 1'b1;
        end
    end

    // Every cycle, mid-period, the registered outputs must equal the model.
    always @(negedge clk) begin
        total++;
        if ({dOut, chOut, dValid} !== {mD, 2'(mCh), mValid}) begin
            bad++;
            $display("[TB] FAIL model t=%0t: d=%h ch=%0d valid=%0b, expected d=%h ch=%0d valid=%0b",
                     $time, dOut, chOut, dValid, mD, mCh, mValid);
        end
    end

    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] en,
                                 input logic [3:0] dw, input logic [31:0] data);
        @(negedge clk);
        mode = m; sel = s; chEn = en; dwell = dw; iData = data;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eD, input logic [1:0] eCh,
                               input logic eV);
        total++;
        if ({dOut, chOut, dValid} !== {eD, eCh, eV}) begin
            bad++;
            $display("[TB] FAIL %s: d=%h ch=%0d valid=%0b, expected d=%h ch=%0d valid=%0b",
                     name, dOut, chOut, dValid, eD, eCh, eV);
        end
    endtask

    localparam logic [31:0] PAT = 32'h44332211;

    initial begin
        logic [1:0] seq [10];
        bit found;
        seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0};

        repeat (3) @(negedge clk);
        checkOutput("reset", 8'h00, 2'd0, 1'b0);
        rstN = 1'b1;

        applyStimulus(1'b0, 2'd2, 4'hF, 4'd0, PAT);
        @(posedge clk); #1;
        checkOutput("manual_sel2", 8'h33, 2'd2, 1'b1);

        applyStimulus(1'b0, 2'd1, 4'b1101, 4'd0, PAT);
        @(posedge clk); #1;
        checkOutput("manual_disabled", 8'h33, 2'd2, 1'b0);

        applyStimulus(1'b1, 2'd0, 4'b1011, 4'd2, PAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("scan_seq%0d", i), chData(PAT, int'(seq[i])), seq[i], 1'b1);
        end

        applyStimulus(1'b1, 2'd0, 4'b1011, 4'd5, PAT);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (chOut == 2'd1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL reach_ch1: ch=%0d, expected 1 within 20 cycles", chOut);
        end
        repeat (2) @(posedge clk);
        applyStimulus(1'b1, 2'd0, 4'b1001, 4'd5, PAT);
        @(posedge clk); #1;
        checkOutput("disable_mid_dwell", 8'h44, 2'd3, 1'b1);
        applyStimulus(1'b1, 2'd0, 4'b0000, 4'd5, PAT);
        @(posedge clk); #1;
        checkOutput("scan_to_none", 8'h44, 2'd3, 1'b0);

        applyStimulus(1'b1, 2'd0, 4'hF, 4'd1, PAT);
        @(posedge clk); #1;
        checkOutput("none_to_scan", 8'h11, 2'd0, 1'b1);
        @(posedge clk);
        applyStimulus(1'b0, 2'd3, 4'hF, 4'd1, PAT);
        @(posedge clk); #1;
        checkOutput("scan_to_manual", 8'h44, 2'd3, 1'b1);

        applyStimulus(1'b1, 2'd0, 4'b0110, 4'd1, PAT);
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("restart_lowest", 8'h22, 2'd1, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            logic       m;
            logic [3:0] en;
            logic [3:0] dw;
            m  = mode;
            en = chEn;
            dw = dwell;
            if ($urandom_range(15) == 0) m = ~m;
            if ($urandom_range(5) == 0) en = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(7) == 0) dw = 4'($urandom_range(3));
            applyStimulus(m, 2'($urandom), en, dw, $urandom);
            if ($urandom_range(199) == 0) begin
                #($urandom_range(3) + 1);
                rstN = 1'b0;
                @(negedge clk);
                rstN = 1'b1;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
